// File: rtl/clahe_frame_scheduler_pkg.sv
// Shared constants, state encoding and small helpers for the CLAHE frame scheduler.
package clahe_frame_scheduler_pkg;

    localparam int TILE_NUM  = 16;
    localparam int BINS      = 256;
    localparam int TILE_W    = $clog2(TILE_NUM);
    localparam int CLR_AW    = 12;
    localparam int CLR_WORDS = TILE_NUM * BINS;

    localparam logic [CLR_AW-1:0] CLR_LAST = CLR_AW'(CLR_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CLEAR = 2'd3
    } sched_state_t;

    function automatic logic is_last_tile(input logic [TILE_W-1:0] tile);
        return tile == TILE_W'(TILE_NUM - 1);
    endfunction

endpackage

// File: rtl/clahe_frame_scheduler_if.sv
// Signal bundle between the frame scheduler (slave side) and its environment:
// video timing, histogram RAM control, CDF engine handshake and mapper LUT select.
interface clahe_frame_scheduler_if;
    import clahe_frame_scheduler_pkg::*;

    logic              enable;
    logic              in_vsync;
    logic              in_href;
    logic              cdf_done;
    logic              hist_acc_en;
    logic              hist_bank_sel;
    logic              cdf_start;
    logic [TILE_W-1:0] cdf_tile;
    logic              clr_en;
    logic [CLR_AW-1:0] clr_addr;
    logic              lut_bank_sel;
    logic              lut_valid;
    logic              busy;
    logic              frame_skip;
    logic              err_timeout;

    modport master (
        output enable, in_vsync, in_href, cdf_done,
        input  hist_acc_en, hist_bank_sel, cdf_start, cdf_tile, clr_en, clr_addr,
               lut_bank_sel, lut_valid, busy, frame_skip, err_timeout
    );

    modport slave (
        input  enable, in_vsync, in_href, cdf_done,
        output hist_acc_en, hist_bank_sel, cdf_start, cdf_tile, clr_en, clr_addr,
               lut_bank_sel, lut_valid, busy, frame_skip, err_timeout
    );

endinterface

// File: rtl/clahe_frame_scheduler_vsync_edge.sv
// One-cycle rise/fall pulses of the frame-valid signal, relative to its registered copy.
module clahe_frame_scheduler_vsync_edge (
    input  logic i_pclk,
    input  logic i_rst,
    input  logic i_vsync,
    output logic o_rise,
    output logic o_fall
);

    logic r_vs_d;

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_vs_d <= 1'b0;
        end else begin
            r_vs_d <= i_vsync;
        end
    end

    assign o_rise = i_vsync & ~r_vs_d;
    assign o_fall = ~i_vsync & r_vs_d;

endmodule

// File: rtl/clahe_frame_scheduler.sv
// Frame-level sequencer: gates histogram accumulation, runs the CDF engine over all
// tiles after each accepted frame, then wipes the processed histogram bank.
module clahe_frame_scheduler
    import clahe_frame_scheduler_pkg::*;
#(
    parameter int CDF_TIMEOUT = 8192
) (
    input  logic                   i_pclk,
    input  logic                   i_rst,
    clahe_frame_scheduler_if.slave bus
);

    localparam int                WAIT_W    = $clog2(CDF_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CDF_TIMEOUT - 1);

    sched_state_t      r_state;
    sched_state_t      w_state_next;
    logic              r_acc_ok;
    logic              r_frame_skip;
    logic              r_hist_bank;
    logic              r_lut_bank;
    logic              r_lut_valid;
    logic              r_err_timeout;
    logic [TILE_W-1:0] r_tile;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CLR_AW-1:0] r_clr_addr;

    logic w_rise;
    logic w_fall;
    logic w_frame_go;
    logic w_advance;
    logic w_timeout_hit;

    clahe_frame_scheduler_vsync_edge u_vsync_edge (
        .i_pclk  (i_pclk),
        .i_rst   (i_rst),
        .i_vsync (bus.in_vsync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A frame is only processed if it was accepted at its rising edge (acc_ok held
    // through the frame), which also guarantees the FSM is idle at its falling edge.
    always_comb begin
        w_state_next  = r_state;
        w_frame_go    = 1'b0;
        w_advance     = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && r_acc_ok) begin
                    w_frame_go   = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.cdf_done) begin
                    w_advance = 1'b1;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_advance     = 1'b1;
                    w_timeout_hit = 1'b1;
                end
                if (w_advance) begin
                    w_state_next = is_last_tile(r_tile) ? ST_CLEAR : ST_START;
                end
            end
            ST_CLEAR: begin
                if (r_clr_addr == CLR_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_acc_ok      <= 1'b0;
            r_frame_skip  <= 1'b0;
            r_hist_bank   <= 1'b0;
            r_lut_bank    <= 1'b0;
            r_lut_valid   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tile        <= '0;
            r_wait_cnt    <= '0;
            r_clr_addr    <= '0;
        end else begin
            if (!bus.in_vsync) begin
                r_acc_ok <= bus.enable & (w_state_next == ST_IDLE);
            end
            r_frame_skip <= w_rise & ~r_acc_ok;

            if (w_frame_go) begin
                r_hist_bank <= ~r_hist_bank;
                r_tile      <= '0;
            end else if (w_advance && !is_last_tile(r_tile)) begin
                r_tile <= r_tile + TILE_W'(1);
            end

            if (r_state == ST_START) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end

            if (w_timeout_hit) begin
                r_err_timeout <= 1'b1;
            end

            // The new LUT set becomes visible to the mapper as soon as the last tile is done.
            if (w_advance && is_last_tile(r_tile)) begin
                r_lut_bank  <= ~r_lut_bank;
                r_lut_valid <= 1'b1;
            end

            if (r_state == ST_CLEAR) begin
                r_clr_addr <= (r_clr_addr == CLR_LAST) ? '0 : r_clr_addr + CLR_AW'(1);
            end
        end
    end

    assign bus.hist_acc_en   = bus.in_href & bus.in_vsync & r_acc_ok;
    assign bus.hist_bank_sel = r_hist_bank;
    assign bus.cdf_start     = (r_state == ST_START);
    assign bus.cdf_tile      = r_tile;
    assign bus.clr_en        = (r_state == ST_CLEAR);
    assign bus.clr_addr      = r_clr_addr;
    assign bus.lut_bank_sel  = r_lut_bank;
    assign bus.lut_valid     = r_lut_valid;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.frame_skip    = r_frame_skip;
    assign bus.err_timeout   = r_err_timeout;

endmodule
